seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 16 +
 rtl/seq_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, registered result and flags out.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FunSel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] OutALU;
  logic             out_valid;
  logic [3:0]       Flags;

  modport master (output A, B, FunSel, in_valid,
                  input  in_ready, OutALU, out_valid, Flags);
  modport slave  (input  A, B, FunSel, in_valid,
                  output in_ready, OutALU, out_valid, Flags);
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, one-bit-per-cycle shifts/rotate.
// Optional shift-add multiplier on FunSel 1001 when SEQ_ALU_MUL_EN is defined (NAND otherwise).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] CNT_ONE = {{CW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [CW:0] CNT_MUL = {1'b1, {CW{1'b0}}};
`endif

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_PASSB = 4'b0001;
  localparam logic [3:0] OP_NOTA  = 4'b0010;
  localparam logic [3:0] OP_NOTB  = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_CMP   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_NAND  = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_LSL   = 4'b1011;
  localparam logic [3:0] OP_LSR   = 4'b1100;
  localparam logic [3:0] OP_ASL   = 4'b1101;
  localparam logic [3:0] OP_ASR   = 4'b1110;
  localparam logic [3:0] OP_CSR   = 4'b1111;

  logic [1:0]       state;
  logic [3:0]       op;
  logic [WIDTH-1:0] work;
  logic [CW:0]      cnt;
  logic             asl_ov;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;      // {Z,C,N,O}
  logic             out_vld;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.OutALU    = result;
  assign bus.Flags     = flags;
  assign bus.out_valid = out_vld;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the operands presented at accept
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ov, sub_ov;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c, imm_o, wr_res;
  logic             is_shift;
  logic [CW-1:0]    shamt;

  assign add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_sum  = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
  assign add_ov   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ov   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign is_shift = (bus.FunSel >= OP_LSL);
  assign shamt    = bus.B[CW-1:0];

  // CMP produces A-B for Z/N but wr_res keeps it out of OutALU
  always_comb begin
    imm_res = bus.A;
    imm_c   = flags[2];
    imm_o   = flags[0];
    wr_res  = 1'b1;
    case (bus.FunSel)
      OP_PASSA: imm_res = bus.A;
      OP_PASSB: imm_res = bus.B;
      OP_NOTA:  imm_res = ~bus.A;
      OP_NOTB:  imm_res = ~bus.B;
      OP_ADD: begin
        imm_res = add_sum[WIDTH-1:0];
        imm_c   = add_sum[WIDTH];
        imm_o   = add_ov;
      end
      OP_SUB: begin
        imm_res = sub_sum[WIDTH-1:0];
        imm_c   = sub_sum[WIDTH];
        imm_o   = sub_ov;
      end
      OP_CMP: begin
        imm_res = sub_sum[WIDTH-1:0];
        imm_c   = sub_sum[WIDTH];
        imm_o   = sub_ov;
        wr_res  = 1'b0;
      end
      OP_AND:  imm_res = bus.A & bus.B;
      OP_OR:   imm_res = bus.A | bus.B;
`ifndef SEQ_ALU_MUL_EN
      OP_NAND: imm_res = ~(bus.A & bus.B);
`endif
      OP_XOR:  imm_res = bus.A ^ bus.B;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One shift step on the working register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             sh_msb_chg;

  always_comb begin
    sh_next = work;
    sh_out  = 1'b0;
    case (op)
      OP_LSL, OP_ASL: begin
        sh_next = {work[WIDTH-2:0], 1'b0};
        sh_out  = work[WIDTH-1];
      end
      OP_LSR: begin
        sh_next = {1'b0, work[WIDTH-1:1]};
        sh_out  = work[0];
      end
      OP_ASR: begin
        sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
        sh_out  = work[0];
      end
      OP_CSR: begin
        sh_next = {work[0], work[WIDTH-1:1]};
        sh_out  = work[0];
      end
      default: ;
    endcase
  end

  assign sh_msb_chg = (sh_next[WIDTH-1] != work[WIDTH-1]);

`ifdef SEQ_ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Shift-add multiplier: work holds the high half, mul_lo the multiplier
  // bits being consumed from the bottom while product bits enter from the top.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mul_a, mul_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, work} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mul_lo[WIDTH-1:1]};
`endif

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op      <= 4'd0;
      work    <= '0;
      cnt     <= '0;
      asl_ov  <= 1'b0;
      result  <= '0;
      flags   <= 4'd0;
      out_vld <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mul_a   <= '0;
      mul_lo  <= '0;
`endif
    end else begin
      out_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op <= bus.FunSel;
            if (is_shift) begin
              if (shamt == '0) begin
                // zero count: pass A through, carry untouched, ASL saw no MSB change
                result  <= bus.A;
                flags   <= {~|bus.A, flags[2], bus.A[WIDTH-1],
                            (bus.FunSel == OP_ASL) ? 1'b0 : flags[0]};
                out_vld <= 1'b1;
              end else begin
                work   <= bus.A;
                cnt    <= {1'b0, shamt};
                asl_ov <= 1'b0;
                state  <= ST_SHIFT;
              end
            end
`ifdef SEQ_ALU_MUL_EN
            else if (bus.FunSel == OP_NAND) begin
              work   <= '0;
              mul_a  <= bus.A;
              mul_lo <= bus.B;
              cnt    <= CNT_MUL;
              state  <= ST_MUL;
            end
`endif
            else begin
              if (wr_res) result <= imm_res;
              flags   <= {~|imm_res, imm_c, imm_res[WIDTH-1], imm_o};
              out_vld <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work   <= sh_next;
          cnt    <= cnt - CNT_ONE;
          asl_ov <= asl_ov | sh_msb_chg;
          if (cnt == CNT_ONE) begin
            result  <= sh_next;
            flags   <= {~|sh_next, sh_out, sh_next[WIDTH-1],
                        (op == OP_ASL) ? (asl_ov | sh_msb_chg) : flags[0]};
            out_vld <= 1'b1;
            state   <= ST_IDLE;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        ST_MUL: begin
          work   <= mul_hi_nx;
          mul_lo <= mul_lo_nx;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result  <= mul_lo_nx;
            flags   <= {~|mul_lo_nx, |mul_hi_nx, mul_lo_nx[WIDTH-1], flags[0]};
            out_vld <= 1'b1;
            state   <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed vectors queue expectations, a forked monitor checks them.
module tb_seq_alu;
  localparam logic [3:0] PASSA = 4'b0000, PASSB = 4'b0001, NOTA = 4'b0010;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0101, CMP = 4'b0110, AND_ = 4'b0111;
  localparam logic [3:0] OR_ = 4'b1000, NAND_ = 4'b1001, XOR_ = 4'b1010;
  localparam logic [3:0] LSL = 4'b1011, LSR = 4'b1100, ASL = 4'b1101, ASR = 4'b1110, CSR = 4'b1111;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] flg;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t exp_q[$];

  seq_alu_if #(.WIDTH(8)) bus();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out_valid: got res=%h flags=%b at cyc %0d, want no output",
                   bus.OutALU, bus.Flags, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.OutALU !== e.res || bus.Flags !== e.flg || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s: got res=%h flags=%b cyc=%0d, want res=%h flags=%b cyc=%0d",
                     e.name, bus.OutALU, bus.Flags, cyc, e.res, e.flg, e.cyc);
          end
        end
      end
    end
  endtask

  // Called at a negedge; drives one request and returns at the negedge after accept.
  task automatic issue(input string name, input logic [3:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                       input int lat);
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      checks++;
      fails++;
      $display("FAIL %s_ready_timeout: got in_ready=0, want 1", name);
    end
    bus.FunSel = f; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    exp_q.push_back('{name, er, ef, cyc + lat});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    exp_t e;
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no out_valid, want res=%h flags=%b", e.name, e.res, e.flg);
    end
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.FunSel = '0; bus.in_valid = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_outalu", {24'd0, bus.OutALU}, 32'h0);
    chk("rst_flags", {28'd0, bus.Flags}, 32'h0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'h1);
    rst = 1'b0;

    // first request on the very first edge with rst low
    issue("add_33_0f", ADD,   8'h33, 8'h0F, 8'h42, 4'b0000, 1);
    issue("add_ovf",   ADD,   8'h7F, 8'h01, 8'h80, 4'b0011, 1);
    issue("sub",       SUB,   8'h07, 8'hFA, 8'h0D, 4'b0000, 1);
    issue("cmp",       CMP,   8'h40, 8'h38, 8'h0D, 4'b0100, 1);
    issue("and",       AND_,  8'hF0, 8'h3C, 8'h30, 4'b0100, 1);
    issue("xor_zero",  XOR_,  8'hAA, 8'hAA, 8'h00, 4'b1100, 1);
    issue("not_a",     NOTA,  8'h0F, 8'h55, 8'hF0, 4'b0110, 1);
    issue("pass_b",    PASSB, 8'h77, 8'h00, 8'h00, 4'b1100, 1);
    issue("or",        OR_,   8'h80, 8'h01, 8'h81, 4'b0110, 1);
`ifdef SEQ_ALU_MUL_EN
    issue("mul",       NAND_, 8'h10, 8'h11, 8'h10, 4'b0100, 9);
`else
    issue("nand",      NAND_, 8'h10, 8'h11, 8'hEF, 4'b0110, 1);
`endif
    issue("add_carry", ADD,   8'h80, 8'h80, 8'h00, 4'b1101, 1);

    // LSR 3: busy for 3 cycles, requests during busy must be dropped
    begin
      int g = 0;
      while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
      bus.FunSel = LSR; bus.A = 8'h33; bus.B = 8'h03; bus.in_valid = 1'b1;
      exp_q.push_back('{"lsr3", 8'h06, 4'b0001, cyc + 4});
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("lsr_busy_ready_%0d", i), {31'd0, bus.in_ready}, 32'h0);
        bus.FunSel = ADD; bus.A = 8'h01; bus.B = 8'h01; bus.in_valid = (i < 2);
      end
      @(negedge clk);
      chk("lsr_done_ready", {31'd0, bus.in_ready}, 32'h1);
    end

    issue("lsl_mod",   LSL,   8'h81, 8'h09, 8'h02, 4'b0101, 2);
    issue("asl_80",    ASL,   8'h80, 8'h01, 8'h00, 4'b1101, 2);
    issue("csr_80",    CSR,   8'h80, 8'h01, 8'h40, 4'b0001, 2);
    issue("asr_90",    ASR,   8'h90, 8'h02, 8'hE4, 4'b0011, 3);
    issue("asr_81",    ASR,   8'h81, 8'h01, 8'hC0, 4'b0111, 2);
    issue("lsr_cnt0",  LSR,   8'h00, 8'h08, 8'h00, 4'b1101, 1);
    issue("asl_20",    ASL,   8'h20, 8'h02, 8'h80, 4'b0011, 3);
    issue("pass_a",    PASSA, 8'h5A, 8'h00, 8'h5A, 4'b0001, 1);
    drain();

    // reset two cycles into LSL 7: op discarded, no late out_valid
    bus.FunSel = LSL; bus.A = 8'h01; bus.B = 8'h07; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rst_outalu", {24'd0, bus.OutALU}, 32'h0);
    chk("midop_rst_flags", {28'd0, bus.Flags}, 32'h0);
    chk("midop_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);
    chk("midop_rst_out_valid", {31'd0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue("add_after_rst", ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 1);
    drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
